axi_lite_master_bridge: RTL and testbench



---
 rtl/axi_lite_master_pkg.sv | 42 ++++
 rtl/axi_lite_master_bridge_if.sv | 60 ++++++
 rtl/axi_lite_timeout_cnt.sv | 28 ++
 rtl/axi_lite_master_bridge.sv | 184 ++++++++++++++++++
 tb/tb_axi_lite_master_bridge.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_master_pkg.sv
// Shared types for the AXI-Lite master bridge.
// Holds the FSM state encoding, the response codes and the command bundle.
package axi_lite_master_pkg;

  localparam int CMD_ADDR_MAX = 32;
  localparam int CMD_DATA_MAX = 64;
  localparam int CMD_STRB_MAX = CMD_DATA_MAX / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_RSP
  } state_e;

  typedef struct packed {
    logic                    write;
    logic [CMD_ADDR_MAX-1:0] addr;
    logic [CMD_DATA_MAX-1:0] wdata;
    logic [CMD_STRB_MAX-1:0] strb;
  } cmd_t;

  function automatic cmd_t pack_cmd(
    input logic                    write,
    input logic [CMD_ADDR_MAX-1:0] addr,
    input logic [CMD_DATA_MAX-1:0] wdata,
    input logic [CMD_STRB_MAX-1:0] strb
  );
    cmd_t c;
    c.write = write;
    c.addr  = addr;
    c.wdata = wdata;
    c.strb  = strb;
    return c;
  endfunction

endpackage

// File: rtl/axi_lite_master_bridge_if.sv
// AXI-Lite bus bundle between a single master and a register slave.
// Master drives address/data/valids, slave drives readies/responses.
interface AXI_LITE #(
  parameter int AXI_ADDR_WIDTH = 4,
  parameter int AXI_DATA_WIDTH = 32
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;

  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [2:0]                aw_prot;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]         w_strb;
  logic                      w_valid;
  logic                      w_ready;

  logic [1:0]                b_resp;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [2:0]                ar_prot;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_addr, aw_prot, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_valid,
    input  w_ready,
    input  b_resp, b_valid,
    output b_ready,
    output ar_addr, ar_prot, ar_valid,
    input  ar_ready,
    input  r_data, r_resp, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_addr, aw_prot, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_valid,
    output w_ready,
    output b_resp, b_valid,
    input  b_ready,
    input  ar_addr, ar_prot, ar_valid,
    output ar_ready,
    output r_data, r_resp, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/axi_lite_timeout_cnt.sv
// Response watchdog for the AXI-Lite master bridge.
// Flags expiry on the TIMEOUT_CYCLES-th enabled cycle since the last clear.
module axi_lite_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt <= '0;
    end else if (enable_i && cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired_o = enable_i && (cnt == LAST);

endmodule

// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding AXI-Lite master: one register command in, one response out.
// Define AXI_LITE_MASTER_TIMEOUT_EN to add the b/r response watchdog.
module axi_lite_master_bridge
  import axi_lite_master_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic [1:0]              rsp_resp_o,
  output logic                    rsp_timeout_o,
  AXI_LITE.Master                 axi_l
);

  localparam int SW = DATA_WIDTH / 8;

  state_e state;

  logic                  aw_v;
  logic                  w_v;
  logic                  ar_v;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [ADDR_WIDTH-1:0] ar_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [SW-1:0]         w_strb_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [1:0]            rsp_resp_q;
  logic                  rsp_timeout_q;

  cmd_t cmd;
  logic unused_cmd;
  logic aw_hs;
  logic w_hs;
  logic expired;

  // Zero-extend into the shared bundle; only the configured widths are kept.
  assign cmd = pack_cmd(cmd_write_i,
                        CMD_ADDR_MAX'(cmd_addr_i),
                        CMD_DATA_MAX'(cmd_wdata_i),
                        CMD_STRB_MAX'(cmd_strb_i));
  assign unused_cmd = ^cmd;

  assign aw_hs = aw_v && axi_l.aw_ready;
  assign w_hs  = w_v && axi_l.w_ready;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  logic waiting;

  assign waiting = (state == S_WR_RESP) || (state == S_RD_DATA);

  axi_lite_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (!waiting),
    .enable_i  (waiting),
    .expired_o (expired)
  );
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;

  assign expired = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      aw_v          <= 1'b0;
      w_v           <= 1'b0;
      ar_v          <= 1'b0;
      aw_addr_q     <= '0;
      ar_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= RESP_OKAY;
      rsp_timeout_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            if (cmd.write) begin
              aw_addr_q <= cmd.addr[ADDR_WIDTH-1:0];
              w_data_q  <= cmd.wdata[DATA_WIDTH-1:0];
              w_strb_q  <= cmd.strb[SW-1:0];
              aw_v      <= 1'b1;
              w_v       <= 1'b1;
              state     <= S_WR;
            end else begin
              ar_addr_q <= cmd.addr[ADDR_WIDTH-1:0];
              ar_v      <= 1'b1;
              state     <= S_RD_ADDR;
            end
          end
        end
        S_WR: begin
          if (aw_hs) aw_v <= 1'b0;
          if (w_hs)  w_v  <= 1'b0;
          // Address and data channels may complete in either order.
          if ((aw_hs || !aw_v) && (w_hs || !w_v)) begin
            state <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (axi_l.b_valid) begin
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= axi_l.b_resp;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state         <= S_RSP;
          end else if (expired) begin
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= RESP_SLVERR;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state         <= S_RSP;
          end
        end
        S_RD_ADDR: begin
          if (axi_l.ar_ready) begin
            ar_v  <= 1'b0;
            state <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (axi_l.r_valid) begin
            rsp_rdata_q   <= axi_l.r_data;
            rsp_resp_q    <= axi_l.r_resp;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state         <= S_RSP;
          end else if (expired) begin
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= RESP_SLVERR;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state         <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o   = (state == S_IDLE) && !rst_i;
  assign axi_l.b_ready = (state == S_WR_RESP);
  assign axi_l.r_ready = (state == S_RD_DATA);

  assign axi_l.aw_addr  = aw_addr_q;
  assign axi_l.aw_prot  = 3'b000;
  assign axi_l.aw_valid = aw_v;
  assign axi_l.w_data   = w_data_q;
  assign axi_l.w_strb   = w_strb_q;
  assign axi_l.w_valid  = w_v;
  assign axi_l.ar_addr  = ar_addr_q;
  assign axi_l.ar_prot  = 3'b000;
  assign axi_l.ar_valid = ar_v;

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_resp_o    = rsp_resp_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Testbench for axi_lite_master_bridge with a cycle-stepped slave model.
// Build with AXI_LITE_MASTER_TIMEOUT_EN to exercise the watchdog path.
module tb_axi_lite_master_bridge;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_strb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;

  AXI_LITE #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) axi ();

  axi_lite_master_bridge #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_write_i   (cmd_write),
    .cmd_addr_i    (cmd_addr),
    .cmd_wdata_i   (cmd_wdata),
    .cmd_strb_i    (cmd_strb),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_resp_o    (rsp_resp),
    .rsp_timeout_o (rsp_timeout),
    .axi_l         (axi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    strb;
    int            aw_dly;
    int            w_dly;
    int            ar_dly;
    int            hold;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_resp;
    logic [DW-1:0] exp_rdata;
    logic [1:0]    exp_resp;
  } vec_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    logic          to;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic slave_idle();
    axi.aw_ready = 1'b0;
    axi.w_ready  = 1'b0;
    axi.ar_ready = 1'b0;
    axi.b_valid  = 1'b0;
    axi.b_resp   = 2'b00;
    axi.r_valid  = 1'b0;
    axi.r_data   = '0;
    axi.r_resp   = 2'b00;
  endtask

  task automatic send_cmd(input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [3:0] s);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic consume(input string tag);
    exp_t e;
    rsp_ready = 1'b1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(1), 64'(0));
    end else begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
      chk({tag, "_resp"}, 64'(rsp_resp), 64'(e.resp));
      chk({tag, "_timeout"}, 64'(rsp_timeout), 64'(e.to));
    end
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_rsp_cleared"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_cmd_ready_after"}, 64'(cmd_ready), 64'(1));
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int k = 0, rsp_k = 0, bk = 0, awv = 0, wv = 0, arv = 0, lat;
    string tag;
    tag = $sformatf("vec%0d", idx);
    send_cmd(v.wr, v.addr, v.wdata, v.strb);
    sb.push_back('{v.exp_rdata, v.exp_resp, 1'b0});
    while (rsp_k == 0 && k < 60) begin
      @(negedge clk);
      k++;
      if (axi.aw_valid) begin
        awv++;
        chk({tag, "_aw_addr"}, 64'(axi.aw_addr), 64'(v.addr));
      end
      if (axi.w_valid) begin
        wv++;
        chk({tag, "_w_data"}, 64'(axi.w_data), 64'(v.wdata));
        chk({tag, "_w_strb"}, 64'(axi.w_strb), 64'(v.strb));
      end
      if (axi.ar_valid) begin
        arv++;
        chk({tag, "_ar_addr"}, 64'(axi.ar_addr), 64'(v.addr));
      end
      if ((axi.b_ready || axi.r_ready) && bk == 0) bk = k;
      if (rsp_valid) rsp_k = k;
      axi.aw_ready = (k == 1 + v.aw_dly);
      axi.w_ready  = (k == 1 + v.w_dly);
      axi.ar_ready = (k == 1 + v.ar_dly);
      axi.b_valid  = axi.b_ready;
      axi.b_resp   = v.s_resp;
      axi.r_valid  = axi.r_ready;
      axi.r_data   = v.s_rdata;
      axi.r_resp   = v.s_resp;
    end
    slave_idle();
    if (v.wr) lat = 3 + ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly);
    else      lat = 3 + v.ar_dly;
    chk({tag, "_rsp_latency"}, 64'(rsp_k), 64'(lat));
    chk({tag, "_br_ready_start"}, 64'(bk), 64'(lat - 1));
    chk({tag, "_aw_cycles"}, 64'(awv), 64'(v.wr ? 1 + v.aw_dly : 0));
    chk({tag, "_w_cycles"}, 64'(wv), 64'(v.wr ? 1 + v.w_dly : 0));
    chk({tag, "_ar_cycles"}, 64'(arv), 64'(v.wr ? 0 : 1 + v.ar_dly));
    if (rsp_k == 0) begin
      pulse_reset();
      return;
    end
    for (int h = 0; h < v.hold; h++) begin
      rsp_ready = 1'b0;
      chk({tag, "_hold_valid"}, 64'(rsp_valid), 64'(1));
      chk({tag, "_hold_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
      chk({tag, "_hold_resp"}, 64'(rsp_resp), 64'(v.exp_resp));
      chk({tag, "_hold_cmd_ready"}, 64'(cmd_ready), 64'(0));
      @(negedge clk);
    end
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(1));
    consume(tag);
  endtask

  task automatic reset_mid_write();
    send_cmd(1'b1, 4'h4, 32'h0BAD_F00D, 4'hF);
    sb.push_back('{32'h0, 2'b00, 1'b0});
    @(negedge clk);
    chk("rst_aw_pending", 64'(axi.aw_valid), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    chk("rst_aw_valid", 64'(axi.aw_valid), 64'(0));
    chk("rst_w_valid", 64'(axi.w_valid), 64'(0));
    chk("rst_ar_valid", 64'(axi.ar_valid), 64'(0));
    chk("rst_b_ready", 64'(axi.b_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready_after", 64'(cmd_ready), 64'(1));
    chk("rst_no_rsp", 64'(rsp_valid), 64'(0));
  endtask

  task automatic stalled_b();
    int k = 0, rsp_k = 0, bk = 0;
    send_cmd(1'b1, 4'hC, 32'h5555_AAAA, 4'hF);
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    sb.push_back('{32'h0, 2'b10, 1'b1});
    while (rsp_k == 0 && k < 60) begin
      @(negedge clk);
      k++;
      if (axi.b_ready && bk == 0) bk = k;
      if (rsp_valid) rsp_k = k;
      axi.aw_ready = (k == 1);
      axi.w_ready  = (k == 1);
    end
    slave_idle();
    chk("to_b_ready_start", 64'(bk), 64'(2));
    chk("to_rsp_latency", 64'(rsp_k), 64'(2 + TO));
    chk("to_b_ready_dropped", 64'(axi.b_ready), 64'(0));
    consume("to");
    axi.b_valid = 1'b1;
    @(negedge clk);
    chk("to_late_b_ignored", 64'(axi.b_ready), 64'(0));
    slave_idle();
    pulse_reset();
`else
    sb.push_back('{32'h0, 2'b00, 1'b0});
    for (k = 1; k <= 24; k++) begin
      @(negedge clk);
      axi.aw_ready = (k == 1);
      axi.w_ready  = (k == 1);
    end
    chk("stall_b_ready", 64'(axi.b_ready), 64'(1));
    chk("stall_no_rsp", 64'(rsp_valid), 64'(0));
    chk("stall_timeout", 64'(rsp_timeout), 64'(0));
    axi.b_valid = 1'b1;
    axi.b_resp  = 2'b00;
    @(negedge clk);
    slave_idle();
    chk("stall_rsp_valid", 64'(rsp_valid), 64'(1));
    consume("stall");
`endif
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    rsp_ready = 1'b0;
    slave_idle();

    vecs[0] = '{1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0,
                32'h0, 2'b00, 32'h0, 2'b00};
    vecs[1] = '{1'b0, 4'h8, 32'h0, 4'h0, 0, 0, 0, 0,
                32'h12345678, 2'b00, 32'h12345678, 2'b00};
    vecs[2] = '{1'b1, 4'hC, 32'h0000A5A5, 4'h3, 0, 3, 0, 0,
                32'h0, 2'b00, 32'h0, 2'b00};
    vecs[3] = '{1'b0, 4'h0, 32'h0, 4'h0, 0, 0, 0, 5,
                32'hCAFEF00D, 2'b10, 32'hCAFEF00D, 2'b10};
    vecs[4] = '{1'b1, 4'h2, 32'h01020304, 4'h5, 2, 0, 0, 1,
                32'hFFFFFFFF, 2'b10, 32'h0, 2'b10};
    vecs[5] = '{1'b0, 4'hE, 32'h0, 4'h0, 0, 0, 2, 0,
                32'h87654321, 2'b00, 32'h87654321, 2'b00};
    vecs[6] = '{1'b1, 4'h6, 32'h13579BDF, 4'h8, 1, 1, 0, 2,
                32'h0, 2'b00, 32'h0, 2'b00};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("reset_rsp_resp", 64'(rsp_resp), 64'(0));
    chk("reset_rsp_timeout", 64'(rsp_timeout), 64'(0));
    chk("reset_valids",
        64'({axi.aw_valid, axi.w_valid, axi.ar_valid}), 64'(0));
    chk("reset_readies", 64'({axi.b_ready, axi.r_ready}), 64'(0));
    chk("reset_addrs", 64'({axi.aw_addr, axi.ar_addr}), 64'(0));
    chk("reset_wdata", 64'(axi.w_data), 64'(0));
    chk("reset_wstrb", 64'(axi.w_strb), 64'(0));
    chk("reset_prot", 64'({axi.aw_prot, axi.ar_prot}), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    reset_mid_write();
    run_vec(vecs[1], 7);
    stalled_b();
    run_vec(vecs[0], 8);

    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
